// File: rtl/bin2bcd_seq.sv
// Sequential 10-bit binary to 3-digit BCD converter (double dabble, one bit per cycle).
// Inputs above 999 either clamp to 999 or wrap modulo 1000, and always raise overflow.
module bin2bcd_seq #(
    parameter bit          SATURATE = 1'b1,
    parameter int unsigned ITER     = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] bin_in,
    output logic       busy,
    output logic       done,
    output logic [3:0] bcd_hundreds,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_units,
    output logic       overflow
);

    localparam int unsigned BIN_W  = 10;
    localparam int unsigned DIG_W  = 4;
    localparam int unsigned NDIG   = 3;
    localparam int unsigned BCD_W  = NDIG * DIG_W;
    localparam int unsigned WORK_W = BCD_W + BIN_W;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned LIMIT  = 999;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                in_ovf_q, in_ovf_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [DIG_W-1:0]    hun_q, hun_d;
    logic [DIG_W-1:0]    ten_q, ten_d;
    logic [DIG_W-1:0]    unit_q, unit_d;
    logic                ovf_q, ovf_d;

    logic [WORK_W-1:0]   adj_c;
    logic [WORK_W:0]     step_c;
    logic                last_step_c;
    logic                clamp_c;

    // One double-dabble step; step_c's top bit is the transient thousands bit.
    always_comb begin
        adj_c = work_q;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (work_q[BIN_W + DIG_W*i +: DIG_W] >= 4'd5) begin
                adj_c[BIN_W + DIG_W*i +: DIG_W] = work_q[BIN_W + DIG_W*i +: DIG_W] + 4'd3;
            end
        end
        step_c = {adj_c, 1'b0};
    end

    assign last_step_c = (cnt_q == CNT_W'(ITER - 1));
    assign clamp_c     = SATURATE && (in_ovf_q || step_c[WORK_W]);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SHIFT;
            S_SHIFT: if (last_step_c) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        work_d   = work_q;
        cnt_d    = cnt_q;
        in_ovf_d = in_ovf_q;
        hun_d    = hun_q;
        ten_d    = ten_q;
        unit_d   = unit_q;
        ovf_d    = ovf_q;
        busy_d   = (state_d == S_SHIFT);
        done_d   = (state_d == S_DONE);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    work_d   = WORK_W'(bin_in);
                    cnt_d    = '0;
                    in_ovf_d = (bin_in > BIN_W'(LIMIT));
                end
            end
            S_SHIFT: begin
                work_d = step_c[WORK_W-1:0];
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_step_c) begin
                    ovf_d = in_ovf_q;
                    if (clamp_c) begin
                        hun_d  = 4'd9;
                        ten_d  = 4'd9;
                        unit_d = 4'd9;
                    end else begin
                        hun_d  = step_c[BIN_W + 2*DIG_W +: DIG_W];
                        ten_d  = step_c[BIN_W + DIG_W   +: DIG_W];
                        unit_d = step_c[BIN_W           +: DIG_W];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            work_q   <= '0;
            cnt_q    <= '0;
            in_ovf_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hun_q    <= '0;
            ten_q    <= '0;
            unit_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            in_ovf_q <= in_ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hun_q    <= hun_d;
            ten_q    <= ten_d;
            unit_q   <= unit_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign bcd_hundreds = hun_q;
    assign bcd_tens     = ten_q;
    assign bcd_units    = unit_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: one clamping and one wrapping instance
// share stimulus and are compared against an arithmetic decimal-digit model.
module tb_bin2bcd_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [9:0] bin_in;

    logic       busy_s, done_s, ovf_s;
    logic [3:0] h_s, t_s, u_s;
    logic       busy_m, done_m, ovf_m;
    logic [3:0] h_m, t_m, u_m;
    logic [12:0] res_s, res_m;

    int n_checks = 0;
    int n_fail   = 0;

    assign res_s = {ovf_s, h_s, t_s, u_s};
    assign res_m = {ovf_m, h_m, t_m, u_m};

    bin2bcd_seq #(.SATURATE(1'b1), .ITER(10)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .busy(busy_s), .done(done_s),
        .bcd_hundreds(h_s), .bcd_tens(t_s), .bcd_units(u_s),
        .overflow(ovf_s)
    );

    bin2bcd_seq #(.SATURATE(1'b0), .ITER(10)) dut_mod (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .busy(busy_m), .done(done_m),
        .bcd_hundreds(h_m), .bcd_tens(t_m), .bcd_units(u_m),
        .overflow(ovf_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: overflow flag plus three decimal digits from plain arithmetic
    function automatic logic [12:0] ref_res(input int v, input bit sat);
        int m;
        if (sat && v > 999) m = 999;
        else                m = v % 1000;
        return {(v > 999) ? 1'b1 : 1'b0, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int v);
        start  = 1'b1;
        bin_in = 10'(v);
        tick();
        start  = 1'b0;
        bin_in = 10'($urandom);
    endtask

    // Waits for done; lat counts edges after the accepting edge
    task automatic wait_done(output int lat, output bit busy_ok, output bit hold_ok);
        logic [25:0] snap;
        snap    = {res_s, res_m};
        lat     = 0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        while (!(done_s === 1'b1 || done_m === 1'b1) && lat < 40) begin
            if (busy_s !== 1'b1 || busy_m !== 1'b1) busy_ok = 1'b0;
            if ({res_s, res_m} !== snap) hold_ok = 1'b0;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; bin_in = '0;
        repeat (2) tick();
        n_checks++;
        if ({busy_s, done_s, res_s, busy_m, done_m, res_m} !== 30'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected 0",
                     {busy_s, done_s, res_s, busy_m, done_m, res_m});
        end
        rst = 1'b0;
    endtask

    task automatic test_zero;
        int lat; bit bok, hok;
        pulse_start(0);
        wait_done(lat, bok, hok);
        n_checks++;
        if ({lat == 10, done_s, done_m} !== 3'b111) begin
            n_fail++;
            $display("FAIL zero_latency: got lat=%0d done=%b%b expected lat=10 done=11", lat, done_s, done_m);
        end
        n_checks++;
        if (bok !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_busy: busy not high in every conversion cycle");
        end
        n_checks++;
        if ({res_s, res_m} !== {ref_res(0, 1), ref_res(0, 0)}) begin
            n_fail++;
            $display("FAIL zero_digits: got %h/%h expected %h/%h", res_s, res_m, ref_res(0, 1), ref_res(0, 0));
        end
        tick();
        n_checks++;
        if ({busy_s, done_s, busy_m, done_m} !== 4'b0) begin
            n_fail++;
            $display("FAIL zero_idle: got busy/done %b%b %b%b expected 00 00", busy_s, done_s, busy_m, done_m);
        end
    endtask

    task automatic test_back_to_back;
        int lat; bit bok, hok;
        pulse_start(255);
        wait_done(lat, bok, hok);
        n_checks++;
        if ({res_s, res_m} !== {ref_res(255, 1), ref_res(255, 0)}) begin
            n_fail++;
            $display("FAIL b2b_255: got %h/%h expected %h/%h", res_s, res_m, ref_res(255, 1), ref_res(255, 0));
        end
        // A start raised in the DONE cycle must be ignored; the IDLE one after it accepted
        start = 1'b1; bin_in = 10'd5;
        tick();
        pulse_start(999);
        wait_done(lat, bok, hok);
        n_checks++;
        if ({lat == 10, done_s, done_m, bok, hok} !== 5'b11111) begin
            n_fail++;
            $display("FAIL b2b_timing: got lat=%0d done=%b%b busy_ok=%b hold_ok=%b expected lat=10 all 1",
                     lat, done_s, done_m, bok, hok);
        end
        n_checks++;
        if ({res_s, res_m} !== {ref_res(999, 1), ref_res(999, 0)}) begin
            n_fail++;
            $display("FAIL b2b_999: got %h/%h expected %h/%h", res_s, res_m, ref_res(999, 1), ref_res(999, 0));
        end
        tick();
    endtask

    task automatic test_overflow;
        int lat; bit bok, hok;
        pulse_start(1023);
        wait_done(lat, bok, hok);
        n_checks++;
        if (res_s !== 13'h1999) begin
            n_fail++;
            $display("FAIL ovf_saturate: got %h expected 1999", res_s);
        end
        n_checks++;
        if (res_m !== 13'h1023) begin
            n_fail++;
            $display("FAIL ovf_modulo: got %h expected 1023", res_m);
        end
        tick();
    endtask

    task automatic test_ignore_start;
        int ndone;
        logic [25:0] seen;
        ndone = 0;
        seen  = '0;
        pulse_start(500);
        repeat (3) tick();
        pulse_start(7);
        for (int k = 0; k < 20; k++) begin
            if (done_s === 1'b1 || done_m === 1'b1) begin
                ndone++;
                seen = {res_s, res_m};
            end
            tick();
        end
        n_checks++;
        if (ndone !== 1) begin
            n_fail++;
            $display("FAIL ignore_count: got %0d done pulses expected 1", ndone);
        end
        n_checks++;
        if (seen !== {ref_res(500, 1), ref_res(500, 0)}) begin
            n_fail++;
            $display("FAIL ignore_digits: got %h expected %h", seen, {ref_res(500, 1), ref_res(500, 0)});
        end
    endtask

    task automatic test_reset_abort;
        int lat; bit bok, hok;
        pulse_start(321);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({busy_s, done_s, res_s, busy_m, done_m, res_m} !== 30'b0) begin
            n_fail++;
            $display("FAIL abort_clear: got %h expected 0", {busy_s, done_s, res_s, busy_m, done_m, res_m});
        end
        pulse_start(42);
        wait_done(lat, bok, hok);
        n_checks++;
        if ({lat == 10, done_s, done_m, bok} !== 4'b1111) begin
            n_fail++;
            $display("FAIL abort_restart: got lat=%0d done=%b%b busy_ok=%b expected lat=10 all 1",
                     lat, done_s, done_m, bok);
        end
        n_checks++;
        if ({res_s, res_m} !== {ref_res(42, 1), ref_res(42, 0)}) begin
            n_fail++;
            $display("FAIL abort_42: got %h/%h expected %h/%h", res_s, res_m, ref_res(42, 1), ref_res(42, 0));
        end
        tick();
    endtask

    task automatic test_sweep;
        int lat; bit bok, hok;
        for (int v = 0; v < 1024; v++) begin
            repeat ($urandom_range(0, 2)) tick();
            pulse_start(v);
            wait_done(lat, bok, hok);
            n_checks++;
            if ({lat == 10, done_s, done_m} !== 3'b111) begin
                n_fail++;
                $display("FAIL sweep_latency v=%0d: got lat=%0d done=%b%b expected lat=10 done=11", v, lat, done_s, done_m);
            end
            n_checks++;
            if ({bok, hok} !== 2'b11) begin
                n_fail++;
                $display("FAIL sweep_busy_hold v=%0d: got busy_ok=%b hold_ok=%b expected 11", v, bok, hok);
            end
            n_checks++;
            if (res_s !== ref_res(v, 1)) begin
                n_fail++;
                $display("FAIL sweep_sat v=%0d: got %h expected %h", v, res_s, ref_res(v, 1));
            end
            n_checks++;
            if (res_m !== ref_res(v, 0)) begin
                n_fail++;
                $display("FAIL sweep_mod v=%0d: got %h expected %h", v, res_m, ref_res(v, 0));
            end
            tick();
            n_checks++;
            if ({busy_s, done_s, busy_m, done_m} !== 4'b0) begin
                n_fail++;
                $display("FAIL sweep_done_pulse v=%0d: got %b%b %b%b expected 00 00", v, busy_s, done_s, busy_m, done_m);
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero();
        test_back_to_back();
        test_overflow();
        test_ignore_start();
        test_reset_abort();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
